// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multi-cycle MIPS main control unit:
// opcodes, 4-bit state encodings, ALU/mux select codes, control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dest;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: opcode/mem_ready in, control strobes,
// fetch counter and state debug out. master = controller, slave = datapath.
interface multicycle_controller_if #(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 2,
  parameter int COUNT_W  = 32
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                branch_ne;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dest;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [1:0]          pc_source;
  logic                illegal_op;
  logic [COUNT_W-1:0]  fetch_count;
  logic [3:0]          state_dbg;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, branch_ne,
    output i_or_d, mem_read, mem_write, ir_write,
    output mem_to_reg, reg_dest, reg_write,
    output alu_src_a, alu_src_b, alu_op, pc_source,
    output illegal_op, fetch_count, state_dbg
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, branch_ne,
    input  i_or_d, mem_read, mem_write, ir_write,
    input  mem_to_reg, reg_dest, reg_write,
    input  alu_src_a, alu_src_b, alu_op, pc_source,
    input  illegal_op, fetch_count, state_dbg
  );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational state -> control decode (Moore, except FETCH load strobes).
// Ports: en (0 forces all controls low), state, opcode, mem_ready; ctrl, alu_op.
module mc_output_decode
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 2
) (
  input  logic                en,
  input  state_e              state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output ctrl_t               ctrl,
  output logic [ALU_OP_W-1:0] alu_op
);

  logic [1:0] aop;

  always_comb begin
    ctrl = '0;
    aop  = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        aop            = ALU_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dest  = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        aop                = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = (opcode == OPCODE_W'(OP_BNE));
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ILLEGAL: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ;
    endcase
    // Reset must kill every strobe without waiting for a clock edge.
    if (!en) begin
      ctrl = '0;
      aop  = '0;
    end
    alu_op = ALU_OP_W'(aop);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS main control FSM with memory stall and fetch counter.
// Ports: clk, reset (async, active-high), bus (master: opcode/mem_ready in, controls out).
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W     = 6,
  parameter int ALU_OP_W     = 2,
  parameter int COUNT_W      = 32,
  parameter int SUPPORT_ADDI = 1,
  parameter int SUPPORT_BNE  = 1
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master bus
);

  localparam logic [OPCODE_W-1:0] K_RTYPE = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] K_LW    = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] K_SW    = OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] K_BEQ   = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] K_BNE   = OPCODE_W'(OP_BNE);
  localparam logic [OPCODE_W-1:0] K_J     = OPCODE_W'(OP_J);
  localparam logic [OPCODE_W-1:0] K_ADDI  = OPCODE_W'(OP_ADDI);

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   fcnt_q, fcnt_d;
  logic [OPCODE_W-1:0]  op;
  ctrl_t                ctrl;
  logic [ALU_OP_W-1:0]  alu_op;

  assign op = bus.opcode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
          fcnt_d  = fcnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (op == K_RTYPE)
          state_d = S_EXECUTE;
        else if (op == K_LW || op == K_SW)
          state_d = S_MEM_ADDR;
        else if (op == K_BEQ)
          state_d = S_BRANCH;
        else if (op == K_BNE && SUPPORT_BNE != 0)
          state_d = S_BRANCH;
        else if (op == K_J)
          state_d = S_JUMP;
        else if (op == K_ADDI && SUPPORT_ADDI != 0)
          state_d = S_ADDI_EXEC;
        else
          state_d = S_ILLEGAL;
      end
      // IR holds the opcode, so lw/sw is re-derived here.
      S_MEM_ADDR:
        state_d = (op == K_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:
        if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:
        if (bus.mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_ADDI_WB,
      S_BRANCH, S_JUMP, S_ILLEGAL:
        state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  mc_output_decode #(
    .OPCODE_W (OPCODE_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_dec (
    .en        (!reset),
    .state     (state_q),
    .opcode    (op),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl),
    .alu_op    (alu_op)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.branch_ne     = ctrl.branch_ne;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dest      = ctrl.reg_dest;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.fetch_count   = fcnt_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller: default build,
// a no-BNE build and a 4-bit fetch counter build driven in lockstep.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op  = '0;
  logic       rdy = 1'b0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_controller_if b0 ();
  multicycle_controller_if b1 ();
  multicycle_controller_if #(.COUNT_W(4)) b2 ();

  assign b0.opcode = op;
  assign b0.mem_ready = rdy;
  assign b1.opcode = op;
  assign b1.mem_ready = rdy;
  assign b2.opcode = op;
  assign b2.mem_ready = rdy;

  multicycle_controller u0 (.clk(clk), .reset(rst), .bus(b0));
  multicycle_controller #(.SUPPORT_BNE(0)) u1 (
    .clk(clk), .reset(rst), .bus(b1));
  multicycle_controller #(.COUNT_W(4)) u2 (
    .clk(clk), .reset(rst), .bus(b2));

  // {pw,pwc,bne,iod,mr,mw,irw,m2r,rd,rw,asa,asb[2],aop[2],ps[2],ill}
  logic [17:0] ctl0;
  assign ctl0 = {b0.pc_write, b0.pc_write_cond, b0.branch_ne,
                 b0.i_or_d, b0.mem_read, b0.mem_write, b0.ir_write,
                 b0.mem_to_reg, b0.reg_dest, b0.reg_write,
                 b0.alu_src_a, b0.alu_src_b, b0.alu_op,
                 b0.pc_source, b0.illegal_op};

  localparam logic [17:0] C_F1  = 18'b1_0_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [17:0] C_F0  = 18'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [17:0] C_DEC = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [17:0] C_EX  = 18'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [17:0] C_AWB = 18'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [17:0] C_MA  = 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [17:0] C_MRD = 18'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] C_MWB = 18'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [17:0] C_MWR = 18'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] C_IWB = 18'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [17:0] C_BEQ = 18'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [17:0] C_BNE = 18'b0_1_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [17:0] C_JMP = 18'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [17:0] C_ILL = 18'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_1;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] ctl;
    int unsigned cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic cmp(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic r);
    @(negedge clk);
    op  = o;
    rdy = r;
    #1;
  endtask

  task automatic do_reset();
    rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // op, rdy, state, controls, fetch_count (all for u0)
    vecs.push_back('{6'd0,  1'b1, 4'd0,  C_F1,  0});
    vecs.push_back('{6'd0,  1'b0, 4'd1,  C_DEC, 1});
    vecs.push_back('{6'd0,  1'b1, 4'd6,  C_EX,  1});
    vecs.push_back('{6'd0,  1'b1, 4'd7,  C_AWB, 1});
    vecs.push_back('{6'd8,  1'b1, 4'd0,  C_F1,  1});
    vecs.push_back('{6'd8,  1'b1, 4'd1,  C_DEC, 2});
    vecs.push_back('{6'd8,  1'b1, 4'd10, C_MA,  2});
    vecs.push_back('{6'd8,  1'b1, 4'd11, C_IWB, 2});
    vecs.push_back('{6'd35, 1'b1, 4'd0,  C_F1,  2});
    vecs.push_back('{6'd35, 1'b1, 4'd1,  C_DEC, 3});
    vecs.push_back('{6'd35, 1'b1, 4'd2,  C_MA,  3});
    vecs.push_back('{6'd35, 1'b0, 4'd3,  C_MRD, 3});
    vecs.push_back('{6'd35, 1'b0, 4'd3,  C_MRD, 3});
    vecs.push_back('{6'd35, 1'b1, 4'd3,  C_MRD, 3});
    vecs.push_back('{6'd35, 1'b1, 4'd4,  C_MWB, 3});
    vecs.push_back('{6'd43, 1'b0, 4'd0,  C_F0,  3});
    vecs.push_back('{6'd43, 1'b1, 4'd0,  C_F1,  3});
    vecs.push_back('{6'd43, 1'b1, 4'd1,  C_DEC, 4});
    vecs.push_back('{6'd43, 1'b1, 4'd2,  C_MA,  4});
    vecs.push_back('{6'd43, 1'b0, 4'd5,  C_MWR, 4});
    vecs.push_back('{6'd43, 1'b1, 4'd5,  C_MWR, 4});
    vecs.push_back('{6'd4,  1'b1, 4'd0,  C_F1,  4});
    vecs.push_back('{6'd4,  1'b1, 4'd1,  C_DEC, 5});
    vecs.push_back('{6'd4,  1'b1, 4'd8,  C_BEQ, 5});
    vecs.push_back('{6'd5,  1'b1, 4'd0,  C_F1,  5});
    vecs.push_back('{6'd5,  1'b1, 4'd1,  C_DEC, 6});
    vecs.push_back('{6'd5,  1'b1, 4'd8,  C_BNE, 6});
    vecs.push_back('{6'd2,  1'b1, 4'd0,  C_F1,  6});
    vecs.push_back('{6'd2,  1'b1, 4'd1,  C_DEC, 7});
    vecs.push_back('{6'd2,  1'b1, 4'd9,  C_JMP, 7});
    vecs.push_back('{6'd63, 1'b1, 4'd0,  C_F1,  7});
    vecs.push_back('{6'd63, 1'b1, 4'd1,  C_DEC, 8});
    vecs.push_back('{6'd63, 1'b1, 4'd12, C_ILL, 8});
    vecs.push_back('{6'd0,  1'b1, 4'd0,  C_F1,  8});
    vecs.push_back('{6'd0,  1'b1, 4'd1,  C_DEC, 9});

    // Outputs held low during reset even with mem_ready high.
    rdy = 1'b1;
    @(negedge clk);
    #1;
    cmp("rst_ctl", 32'(ctl0), 32'd0);
    cmp("rst_state", 32'(b0.state_dbg), 32'd0);
    cmp("rst_count", b0.fetch_count, 32'd0);
    do_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].rdy);
      cmp($sformatf("v%0d_state", i), 32'(b0.state_dbg),
          32'(vecs[i].st));
      cmp($sformatf("v%0d_ctl", i), 32'(ctl0), 32'(vecs[i].ctl));
      cmp($sformatf("v%0d_cnt", i), b0.fetch_count, vecs[i].cnt);
    end

    // bne without BNE support becomes a one-cycle illegal pulse.
    do_reset();
    drive(6'd5, 1'b1);
    drive(6'd5, 1'b1);
    cmp("nobne_dec", 32'(b1.state_dbg), 32'd1);
    drive(6'd5, 1'b1);
    cmp("nobne_state", 32'(b1.state_dbg), 32'd12);
    cmp("nobne_ill", 32'(b1.illegal_op), 32'd1);
    cmp("nobne_pwc", 32'(b1.pc_write_cond), 32'd0);
    drive(6'd0, 1'b0);
    cmp("nobne_back", 32'(b1.state_dbg), 32'd0);
    cmp("nobne_ill0", 32'(b1.illegal_op), 32'd0);

    // Async reset in the middle of a stalled store.
    do_reset();
    drive(6'd43, 1'b1);
    drive(6'd43, 1'b1);
    drive(6'd43, 1'b1);
    drive(6'd43, 1'b0);
    cmp("sw_mw_on", 32'(b0.mem_write), 32'd1);
    #1 rst = 1'b1;
    #1;
    cmp("async_mw", 32'(b0.mem_write), 32'd0);
    cmp("async_ctl", 32'(ctl0), 32'd0);
    cmp("async_state", 32'(b0.state_dbg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp("rel_state", 32'(b0.state_dbg), 32'd0);
    cmp("rel_count", b0.fetch_count, 32'd0);

    // 17 jumps: 4-bit counter runs 15 -> 0 -> 1.
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      drive(6'd2, 1'b1);
      cmp($sformatf("j%0d_pre", k), 32'(b2.fetch_count),
          32'((k - 1) % 16));
      drive(6'd2, 1'b1);
      drive(6'd2, 1'b1);
      cmp($sformatf("j%0d_pw", k), 32'(b2.pc_write), 32'd1);
      cmp($sformatf("j%0d_ps", k), 32'(b2.pc_source), 32'd2);
      cmp($sformatf("j%0d_cnt", k), 32'(b2.fetch_count),
          32'(k % 16));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle MIPS main control unit; next generation of the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states instead of decoding in one step.
- Supports a memory-ready stall handshake and optional ADDI/BNE support, flags illegal opcodes, and counts retired fetches.
- Sits between the instruction register opcode field and the shared-memory multi-cycle datapath.

Parameters:
OPCODE_W, 6, opcode field width
ALU_OP_W, 2, width of alu_op to ALU control (00 add, 01 sub, 10 funct-decode)
COUNT_W, 32, width of fetch counter
SUPPORT_ADDI, 1, 1 enables opcode 001000 (addi); 0 treats it as illegal
SUPPORT_BNE, 1, 1 enables opcode 000101 (bne); 0 treats it as illegal

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
opcode  input  OPCODE_W  instruction[31:26] from the instruction register
mem_ready  input  1  memory completes the current read/write this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if branch condition holds
branch_ne  output  1  1 selects the not-equal condition for pc_write_cond
i_or_d  output  1  memory address select (0 PC, 1 ALUOut)
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
mem_to_reg  output  1  write-back select (0 ALUOut, 1 MDR)
reg_dest  output  1  destination select (0 rt, 1 rd)
reg_write  output  1  register file write enable
alu_src_a  output  1  (0 PC, 1 A)
alu_src_b  output  2  (00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2)
alu_op  output  ALU_OP_W  ALU control class
pc_source  output  2  (00 ALU, 01 ALUOut, 10 jump target)
illegal_op  output  1  one-cycle pulse on an unsupported opcode
fetch_count  output  COUNT_W  number of completed fetches
state_dbg  output  4  current state encoding

Behaviour:
- Reset: async; state<=FETCH; fetch_count<=0.
  - While reset is high, every output except state_dbg is forced 0.
  - state_dbg reads FETCH.
- Outputs are Moore-decoded from the state register. Exception: ir_write and pc_write in FETCH are qualified by mem_ready.
- Any control not listed for a state is 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - fetch_count increments on that edge and wraps modulo 2^COUNT_W.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000101 with SUPPORT_BNE -> BRANCH
  - 000010 -> JUMP
  - 001000 with SUPPORT_ADDI -> ADDI_EXEC
  - anything else -> ILLEGAL
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD (lw) or MEM_WR (sw). The opcode is re-sampled here; the IR holds it stable.
- MEM_RD: mem_read=1, i_or_d=1. Held until mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dest=0 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Held until mem_ready, then -> FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB.
- ALU_WB: reg_write=1, reg_dest=1, mem_to_reg=0 -> FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB.
- ADDI_WB: reg_write=1, reg_dest=0, mem_to_reg=0 -> FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - branch_ne=1 iff opcode is 000101.
  - -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- ILLEGAL: illegal_op=1 for exactly one cycle, no writes, PC already advanced -> FETCH.
- Cycle counts at zero wait: R/addi 4, lw 5, sw 4, beq/bne 3, j 3, illegal 3.
- mem_read and mem_write are never both 1. reg_write is never asserted in a state where memory is being accessed.
- Reset mid-instruction: abandons the instruction immediately. No write strobe may survive the reset assertion.
- Unused state encodings -> FETCH with all outputs 0.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI);
  - the 4-bit state encodings;
  - the alu_op, alu_src_b and pc_source code constants.
- One sub-module: mc_output_decode, the combinational state-to-control decode, so the FSM register/next-state logic stays separate.

Test Plan:
- Reset then R-type (opcode 000000), mem_ready=1 -> states FETCH, DECODE, EXECUTE, ALU_WB; reg_write=1, reg_dest=1 only in cycle 4; fetch_count=1.
- lw (100011) with mem_ready low 2 cycles in MEM_RD -> mem_read/i_or_d held 3 cycles; reg_write=1 with mem_to_reg=1 once; 7 cycles total.
- beq (000100) then bne (000101) -> pc_write_cond=1 with branch_ne=0, then 1; pc_source=01; 3 cycles each; with SUPPORT_BNE=0, bne gives an illegal_op pulse instead.
- Opcode 111111 -> illegal_op high exactly 1 cycle; no reg_write, mem_write or pc_write_cond; back to FETCH at cycle 4.
- Reset asserted asynchronously mid-MEM_WR while mem_write=1 -> mem_write drops without waiting for a clock edge; after release state_dbg=FETCH and fetch_count=0.
- COUNT_W=4, 17 back-to-back j (000010) instructions -> fetch_count wraps 15->0->1; pc_write=1, pc_source=10 each JUMP cycle.
